// File: rtl/mar_mem_seq.sv
// Memory address register plus single-outstanding memory access sequencer.
// Range-checks the effective address, waits for mem_ack with a timeout, and returns read data via MDR.
module mar_mem_seq #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MAR_ld,
  input  logic [31:0]       MAR_in,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       wdata,
  output logic [31:0]       MAR,
  output logic [31:0]       MDR,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mar_q, mar_d;
  logic [31:0]         mdr_q, mdr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                op_wr_q, op_wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [31:0]         eff_addr;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_wr_d  = op_wr_q;
    cnt_d    = cnt_q;
    eff_addr = MAR_ld ? MAR_in : mar_q;

    case (state_q)
      S_IDLE: begin
        if (MAR_ld) mar_d = MAR_in;
        if (rd || wr) begin
          if ((rd && wr) || (eff_addr[31:ADDR_W] != '0)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
            addr_d  = eff_addr[ADDR_W-1:0];
            wdata_d = wdata;
            op_wr_d = wr;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout
        if (mem_ack) begin
          if (!op_wr_q) mdr_d = mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) || (state_d == S_ERR);
    err_d  = (state_d == S_ERR);
    cs_d   = (state_d == S_REQ);
    we_d   = (state_d == S_REQ) && op_wr_d;
  end

  assign MAR       = mar_q;
  assign MDR       = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mar_mem_seq.sv
// Self-checking bench for mar_mem_seq: vector table of transactions, scoreboard queue of
// expected completions, and a memory responder that acks in a chosen REQ cycle.
module tb_mar_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        MAR_ld;
  logic [31:0] MAR_in;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] MAR, MDR;
  logic        busy, done, err;
  logic [9:0]  mem_addr;
  logic        mem_cs, mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  mar_mem_seq #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .MAR_ld(MAR_ld), .MAR_in(MAR_in), .rd(rd), .wr(wr),
    .wdata(wdata), .MAR(MAR), .MDR(MDR), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        rd, wr, ld;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;   // REQ cycle in which memory acks; 0 = never
    logic        exp_err;
    int          exp_lat;  // cycles from start edge to done
    int          exp_cs;   // cycles mem_cs is high
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] mdr;
    logic [31:0] mar;
    int          lat;
    int          cs;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] mar_m = '0;
  logic [31:0] mdr_m = '0;

  // Memory responder state
  int          cs_cycles = 0;
  int          txn_cnt = 0;
  int          hold_bad = 0;
  logic        cs_prev = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic        cur_we = 1'b0;
  int          cur_ack_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_cs === 1'b1) begin
        if (!cs_prev) txn_cnt++;
        cs_cycles++;
        if (mem_addr !== cur_addr[9:0] || mem_we !== cur_we || mem_wdata !== cur_wdata)
          hold_bad++;
        mem_ack = (cur_ack_at != 0) && (cs_cycles == cur_ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      cs_prev = mem_cs;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    cur_addr   = v.ld ? v.addr : mar_m;
    cur_wdata  = v.wdata;
    cur_we     = v.wr;
    cur_ack_at = v.ack_at;
    mem_rdata  = v.rdata;
    cs_cycles  = 0;
    hold_bad   = 0;
    MAR_ld = v.ld; MAR_in = v.addr; rd = v.rd; wr = v.wr; wdata = v.wdata;
    if (v.ld) mar_m = v.addr;
    if (!v.exp_err && v.rd) mdr_m = v.rdata;
    e.err = v.exp_err; e.mdr = mdr_m; e.mar = mar_m; e.lat = v.exp_lat; e.cs = v.exp_cs;
    sb_q.push_back(e);
    @(negedge clk);
    MAR_ld = 1'b0; rd = 1'b0; wr = 1'b0;
    lat = 0; got = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) begin lat = k; got = 1; break; end
    end
    e = sb_q.pop_front();
    checks++;
    if (got) passed++;
    else $display("FAIL vec%0d_done_timeout: got no done, expected done within 40 cycles", idx);
    chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(e.lat));
    chk($sformatf("vec%0d_err", idx), {31'b0, err}, {31'b0, e.err});
    chk($sformatf("vec%0d_mdr", idx), MDR, e.mdr);
    chk($sformatf("vec%0d_mar", idx), MAR, e.mar);
    chk($sformatf("vec%0d_cs_cycles", idx), 32'(cs_cycles), 32'(e.cs));
    if (e.cs > 0) chk($sformatf("vec%0d_req_hold_errors", idx), 32'(hold_bad), 32'd0);
    @(negedge clk);
    chk($sformatf("vec%0d_idle_after", idx), {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int   t0, lat, done_seen;
    bit   got;
    //          rd    wr    ld    addr           wdata          rdata          ack err   lat cs
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_03ff, 32'h0,         32'hDEADBEEF,  1, 1'b0,  2, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_02a1, 32'h12345678,  32'h0BAD0BAD,  4, 1'b0,  5, 4};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0,         32'h11111111,  1, 1'b1,  1, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_02a3, 32'h0,         32'h22222222,  1, 1'b1,  1, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_02a5, 32'h0,         32'h33333333,  0, 1'b1, 16, 15};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFEF00D,  1, 1'b0,  2, 1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hA5A5A5A5, 15, 1'b0, 16, 15};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h8000_0001, 32'h0,         32'h44444444,  1, 1'b1,  1, 0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hFEEDFACE,  32'h55555555,  2, 1'b0,  3, 2};

    reset = 1'b1; MAR_ld = 1'b0; MAR_in = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_mar_mdr_xor", MAR | MDR | mem_wdata, 32'd0);
    chk("reset_ctrl", {26'b0, busy, done, err, mem_cs, mem_we, |mem_addr}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset in the second REQ cycle drops the access with no done
    @(negedge clk);
    cur_addr = 32'h2a7; cur_we = 1'b0; cur_ack_at = 0; cs_cycles = 0;
    MAR_ld = 1'b1; MAR_in = 32'h2a7; rd = 1'b1;
    @(negedge clk);
    MAR_ld = 1'b0; rd = 1'b0;
    chk("rst_seq_req1_cs", {31'b0, mem_cs}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_seq_regs_zero", MAR | MDR | mem_wdata | {22'b0, mem_addr}, 32'd0);
    chk("rst_seq_ctrl_zero", {27'b0, busy, done, err, mem_cs, mem_we}, 32'd0);
    mar_m = '0; mdr_m = '0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("rst_seq_no_done", 32'(done_seen), 32'd0);

    // MAR_ld / rd pulses while busy must be ignored
    @(negedge clk);
    cur_addr = 32'h011; cur_we = 1'b0; cur_ack_at = 3; cs_cycles = 0; hold_bad = 0;
    mem_rdata = 32'h600DF00D;
    t0 = txn_cnt;
    MAR_ld = 1'b1; MAR_in = 32'h011; rd = 1'b1;
    @(negedge clk);
    MAR_ld = 1'b1; MAR_in = 32'h222; rd = 1'b1;
    got = 0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) begin MAR_ld = 1'b0; rd = 1'b0; end
      if (done === 1'b1) begin lat = k; got = 1; break; end
    end
    checks++;
    if (got) passed++;
    else $display("FAIL busy_seq_done_timeout: got no done, expected done within 40 cycles");
    chk("busy_seq_latency", 32'(lat), 32'd4);
    chk("busy_seq_err", {31'b0, err}, 32'd0);
    chk("busy_seq_mar", MAR, 32'h011);
    chk("busy_seq_mdr", MDR, 32'h600DF00D);
    chk("busy_seq_cs_cycles", 32'(cs_cycles), 32'd3);
    chk("busy_seq_req_hold_errors", 32'(hold_bad), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("busy_seq_txn_count", 32'(txn_cnt - t0), 32'd1);
    chk("busy_seq_idle", {30'b0, busy, done}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mar_mem_seq.md
# mar_mem_seq

Memory address register and memory access sequencer, the stage directly downstream of the MAR address mux. It captures the selected 32-bit address into the MAR and runs a single read or write transaction against the word-addressed data memory using a chip-select/acknowledge handshake. It range-checks the address, bounds the wait with a timeout, and returns read data through the MDR. One access is in flight at a time.

## Interface
- ADDR_W, 10, memory word-address width (1024 words; the highest fixed mux vector is 0x3ff)
- TIMEOUT, 15, maximum REQ cycles to wait for mem_ack before aborting (≥1)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MAR_ld  in  1  load MAR from MAR_in
- MAR_in  in  32  address from the MAR mux output
- rd  in  1  start a read, sampled only in IDLE
- wr  in  1  start a write, sampled only in IDLE
- wdata  in  32  write data, captured at start
- MAR  out  32  current MAR contents
- MDR  out  32  last successful read data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse (success or error)
- err  out  1  one-cycle pulse coincident with done on a failed access
- mem_addr  out  ADDR_W  MAR[ADDR_W-1:0] of the active access
- mem_cs  out  1  memory select, high only in REQ
- mem_we  out  1  write enable, high in REQ for writes only
- mem_wdata  out  32  captured write data
- mem_rdata  in  32  memory read data, valid when mem_ack is high
- mem_ack  in  1  memory completes the access this cycle

## Operation
- States: IDLE, REQ, DONE, ERR.
- MAR load: in IDLE, MAR_ld=1 updates MAR<=MAR_in. MAR_ld is ignored in every other state.
- Start (IDLE only): the effective address is MAR_in if MAR_ld=1 in the same cycle, otherwise MAR. MAR also loads in that case.
  - rd XOR wr with an in-range address: latch the op, address and wdata, then go to REQ.
  - rd and wr both high: go to ERR. No memory access occurs.
  - Effective address bits [31:ADDR_W] ≠ 0: go to ERR. No memory access occurs.
- REQ:
  - mem_cs=1, mem_we=(op==write). mem_addr and mem_wdata are held constant.
  - The wait counter starts at 1 on REQ entry and increments each cycle.
  - mem_ack=1: a read loads MDR<=mem_rdata on that edge; next state is DONE.
  - mem_ack=0 with counter==TIMEOUT: next state is ERR, and MDR is unchanged.
- DONE: done=1, err=0 for one cycle, then IDLE.
- ERR: done=1, err=1 for one cycle, then IDLE.
- rd/wr asserted outside IDLE are ignored; there is no queueing.
- mem_ack outside REQ is ignored.

## Timing
- Reset: state=IDLE, and MAR, MDR, mem_addr, mem_wdata, counter = 0. busy, done, err, mem_cs, mem_we = 0.
- Reset in any state returns to IDLE at the next edge. An in-flight access is dropped: mem_cs falls and no done is produced.
- Start sampled at edge T. REQ runs from T+1 with mem_cs high.
- With mem_ack in the first REQ cycle: DONE in cycle T+2 with MDR already valid, IDLE in T+3. Minimum start-to-done latency is 2 cycles.
- An ack in REQ cycle k (1≤k≤TIMEOUT) gives done in REQ-entry+k.
- Timeout: ERR in cycle REQ-entry+TIMEOUT, so done/err appears TIMEOUT+1 cycles after start.
- Range/illegal error: ERR in cycle T+1, and mem_cs never asserts.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE/ERR. The access rate is at most one per 3 cycles.
- mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as success.

## Test plan
- Reset, then MAR_ld with MAR_in=0x3ff and rd=1 in the same cycle; memory acks immediately with 0xDEADBEEF. Required: mem_addr=0x3ff, mem_cs one cycle, done at T+2, MDR=0xDEADBEEF, MAR=0x3ff, err=0.
- Write to 0x2a1 with wdata=0x12345678 and ack after 3 wait cycles. Required: mem_we=1 and mem_wdata=0x12345678 held for 4 REQ cycles, done on the 5th cycle after start, MDR unchanged.
- Read from 0x400. Required: err=done=1 at T+1, mem_cs never high, MDR unchanged.
- rd=wr=1 at 0x2a3. Required: err pulse at T+1, no memory access.
- Read to 0x2a5 with no ack, TIMEOUT=15. Required: mem_cs high exactly 15 cycles, then err=done=1, then IDLE. A second read acked immediately then succeeds normally.
- Read to 0x2a7, assert reset in the 2nd REQ cycle. Required: all outputs 0 next cycle, no done. MAR_ld/rd pulses applied while busy are ignored: MAR and transaction count unchanged.
